// File: rtl/f5_pkg.sv
// Shared definitions for the F5 weight sequencer: FSM encoding and default sizing.
package f5_pkg;

  // Default layer geometry: 120 neurons of 256 weights, addressed by a 15-bit ROM.
  localparam int F5_NW      = 256;
  localparam int F5_NUM     = 120;
  localparam int F5_AW      = 15;

  // Cycles from ROM read strobe to valid ROM data.
  localparam int F5_ROM_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_MAC = 3'd3,
    ST_DONE     = 3'd4
  } f5_state_e;

endpackage

// File: rtl/f5_rd_pipe.sv
// Read-return pipeline: delays the ROM read strobe (and the end-of-row flag)
// so that the weight-buffer write lines up with the registered ROM word.
module f5_rd_pipe
  import f5_pkg::*;
#(
  parameter int WD = 8
) (
  input  logic          i_sclk,
  input  logic          i_rst,
  input  logic          i_rd,
  input  logic          i_last,
  input  logic [WD-1:0] i_rom_data,
  output logic          o_en,
  output logic          o_last,
  output logic [WD-1:0] o_data
);

  // ROM latency stages plus one stage for the captured word.
  localparam int NSTG = F5_ROM_LAT + 1;

  logic [NSTG-1:0] vld_q;
  logic [NSTG-1:0] last_q;
  logic [WD-1:0]   data_q;

  // Shift the read strobe and end-of-row flag; capture ROM data when it is valid.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      vld_q  <= '0;
      last_q <= '0;
      // NOTE: the data word is a single register (not a memory), so it is reset
      // to give a defined all-zero output after reset.
      data_q <= '0;
    end else begin
      vld_q  <= {vld_q[NSTG-2:0], i_rd};
      last_q <= {last_q[NSTG-2:0], i_rd & i_last};
      if (vld_q[F5_ROM_LAT-1]) begin
        data_q <= i_rom_data;
      end
    end
  end

  assign o_en   = vld_q[NSTG-1];
  assign o_last = vld_q[NSTG-1] & last_q[NSTG-1];
  assign o_data = data_q;

endmodule

// File: rtl/f5_weight_sched.sv
// F5 weight sequencer: fetches one neuron row of NW weights from the weight ROM
// into the F5 weight buffer, waits for the MAC to consume it, and repeats for
// all NUM neurons of a layer pass.
module f5_weight_sched
  import f5_pkg::*;
#(
  parameter int WD  = 8,
  parameter int NW  = F5_NW,
  parameter int NUM = F5_NUM,
  parameter int AW  = F5_AW
) (
  input  logic          i_sclk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_hold,
  input  logic          i_mac_done,
  output logic          o_rom_rd,
  output logic [AW-1:0] o_rom_addr,
  input  logic [WD-1:0] i_rom_data,
  output logic          o_weight_en,
  output logic [WD-1:0] o_weight_data,
  output logic [7:0]    o_neuron,
  output logic          o_row_ready,
  output logic          o_busy,
  output logic          o_done
);

  // Element counter must be able to hold NW itself after the last read of a row.
  localparam int KW = $clog2(NW + 1);

  f5_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [KW-1:0]   k_q,     k_d;
  logic [7:0]      neuron_q, neuron_d;

  logic            rd;
  logic            last_k;
  logic            row_ready;

  // A read issues on every FETCH cycle that is not held.
  assign rd     = (state_q == ST_FETCH) && !i_hold;
  assign last_k = (k_q == KW'(NW - 1));

  // Next-state and counter update logic.
  always_comb begin
    // NOTE: every signal driven here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    k_d      = k_q;
    neuron_d = neuron_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_FETCH;
          addr_d   = '0;
          k_d      = '0;
          neuron_d = 8'd1;
        end
      end

      ST_FETCH: begin
        if (!i_hold) begin
          addr_d = addr_q + AW'(1);
          k_d    = k_q + KW'(1);
          if (last_k) begin
            state_d = ST_DRAIN;
          end
        end
      end

      // The last write of the row coincides with row_ready; nothing is left in flight after it.
      ST_DRAIN: begin
        if (row_ready) begin
          state_d = ST_WAIT_MAC;
        end
      end

      // The address keeps counting linearly, so row n starts at (n-1)*NW.
      ST_WAIT_MAC: begin
        if (i_mac_done) begin
          if (neuron_q == 8'(NUM)) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_FETCH;
            neuron_d = neuron_q + 8'd1;
            k_d      = '0;
          end
        end
      end

      ST_DONE: begin
        state_d  = ST_IDLE;
        neuron_d = 8'd0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      k_q      <= '0;
      neuron_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      neuron_q <= neuron_d;
    end
  end

  f5_rd_pipe #(
    .WD (WD)
  ) u_rd_pipe (
    .i_sclk     (i_sclk),
    .i_rst      (i_rst),
    .i_rd       (rd),
    .i_last     (last_k),
    .i_rom_data (i_rom_data),
    .o_en       (o_weight_en),
    .o_last     (row_ready),
    .o_data     (o_weight_data)
  );

  assign o_rom_rd    = rd;
  assign o_rom_addr  = addr_q;
  assign o_neuron    = neuron_q;
  assign o_row_ready = row_ready;
  assign o_busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                       (state_q == ST_WAIT_MAC);
  assign o_done      = (state_q == ST_DONE);

endmodule
